// File: rtl/div_frame_ctrl.sv
// div_frame_ctrl: byte-stream front end for the 32-bit serial divider.
// Collects a 9-byte request (cmd, dividend, divisor) from the UART receiver,
// drives the operands onto the divider, waits for a fresh run, and returns
// quotient and remainder as 8 bytes to the UART transmitter.
module div_frame_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divider,
    output logic        div_sign,
    input  logic        div_ready,
    input  logic [31:0] div_result,
    input  logic [31:0] div_remainder,
    output logic        busy,
    output logic        frame_err,
    output logic        rx_drop
);

    localparam logic [7:0] CMD_UNSIGNED = 8'hA0;
    localparam logic [7:0] CMD_SIGNED   = 8'hA1;
    localparam logic [2:0] LAST_OP_BYTE = 3'd3;
    localparam logic [2:0] LAST_TX_BYTE = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        OPA,
        OPB,
        WAIT_LOAD,
        BUSY,
        SETTLE,
        SEND
    } state_t;

    state_t      state;
    logic [2:0]  byte_cnt;
    logic [31:0] q_reg;
    logic [31:0] r_reg;

    // Byte idx (0 = most significant) of the {quotient, remainder} response
    function automatic logic [7:0] pick_byte(input logic [63:0] w, input logic [2:0] idx);
        logic [63:0] sh;
        sh = w << {idx, 3'b000};
        return sh[63:56];
    endfunction

    // Frame controller: intake, divider handshake, and response serialisation
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            byte_cnt     <= 3'd0;
            div_dividend <= 32'd0;
            div_divider  <= 32'd0;
            div_sign     <= 1'b0;
            q_reg        <= 32'd0;
            r_reg        <= 32'd0;
            tx_data      <= 8'd0;
            tx_valid     <= 1'b0;
            busy         <= 1'b0;
            frame_err    <= 1'b0;
            rx_drop      <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            rx_drop   <= 1'b0;

            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        if (rx_data == CMD_UNSIGNED || rx_data == CMD_SIGNED) begin
                            div_sign <= rx_data[0];
                            byte_cnt <= 3'd0;
                            busy     <= 1'b1;
                            state    <= OPA;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end

                OPA: begin
                    if (rx_valid) begin
                        div_dividend <= {div_dividend[23:0], rx_data};
                        if (byte_cnt == LAST_OP_BYTE) begin
                            byte_cnt <= 3'd0;
                            state    <= OPB;
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end
                end

                OPB: begin
                    if (rx_valid) begin
                        div_divider <= {div_divider[23:0], rx_data};
                        if (byte_cnt == LAST_OP_BYTE) begin
                            byte_cnt <= 3'd0;
                            state    <= WAIT_LOAD;
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                        end
                    end
                end

                // Divider loads our operands on the edge it is seen ready
                WAIT_LOAD: begin
                    rx_drop <= rx_valid;
                    if (div_ready) begin
                        state <= BUSY;
                    end
                end

                BUSY: begin
                    rx_drop <= rx_valid;
                    if (div_ready) begin
                        state <= SETTLE;
                    end
                end

                // Remainder lags the quotient by one edge; capture both here
                SETTLE: begin
                    rx_drop  <= rx_valid;
                    q_reg    <= div_result;
                    r_reg    <= div_remainder;
                    tx_data  <= div_result[31:24];
                    tx_valid <= 1'b1;
                    byte_cnt <= 3'd0;
                    state    <= SEND;
                end

                SEND: begin
                    rx_drop <= rx_valid;
                    if (tx_valid && tx_ready) begin
                        if (byte_cnt == LAST_TX_BYTE) begin
                            tx_valid <= 1'b0;
                            byte_cnt <= 3'd0;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            byte_cnt <= byte_cnt + 3'd1;
                            tx_data  <= pick_byte({q_reg, r_reg}, byte_cnt + 3'd1);
                        end
                    end
                end

                default: begin
                    busy     <= 1'b0;
                    tx_valid <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_frame_ctrl.sv
// Testbench for div_frame_ctrl: free-running divider model, directed frames
// from the test plan, then randomized frames checked against plain arithmetic.
module tb_div_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] div_dividend;
    logic [31:0] div_divider;
    logic        div_sign;
    logic        div_ready;
    logic [31:0] div_result = 32'd0;
    logic [31:0] div_remainder = 32'd0;
    logic        busy;
    logic        frame_err;
    logic        rx_drop;

    int n_cmp  = 0;
    int n_fail = 0;

    div_frame_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .div_dividend  (div_dividend),
        .div_divider   (div_divider),
        .div_sign      (div_sign),
        .div_ready     (div_ready),
        .div_result    (div_result),
        .div_remainder (div_remainder),
        .busy          (busy),
        .frame_err     (frame_err),
        .rx_drop       (rx_drop)
    );

    always #5 clk = ~clk;

    // Quotient/remainder by plain arithmetic; x/0 gives all-ones and the dividend
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        int sa;
        int sb;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (s) begin
            sa = $signed(a);
            sb = $signed(b);
            return {32'(sa / sb), 32'(sa % sb)};
        end
        return {a / b, a % b};
    endfunction

    // Free-running serial divider: load on ready, 32 iterations, remainder one edge late
    logic [5:0]  dcnt = 6'd7;
    logic [31:0] a_l = 32'd0;
    logic [31:0] b_l = 32'd0;
    logic        s_l = 1'b0;
    logic [31:0] rem_pending = 32'd0;
    logic [63:0] dres;
    assign div_ready = (dcnt == 6'd32);
    always_comb dres = ref_div(a_l, b_l, s_l);

    always @(posedge clk) begin
        if (dcnt == 6'd32) begin
            a_l           <= div_dividend;
            b_l           <= div_divider;
            s_l           <= div_sign;
            div_remainder <= rem_pending;
            dcnt          <= 6'd0;
        end else begin
            dcnt <= dcnt + 6'd1;
            if (dcnt == 6'd31) begin
                div_result  <= dres[63:32];
                rem_pending <= dres[31:0];
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_valid"}, 64'(tx_valid), 64'd0);
        check({tag, "_tx_data"}, 64'(tx_data), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_pulses"}, 64'({frame_err, rx_drop}), 64'd0);
        check({tag, "_operands"}, {div_dividend, div_divider}, 64'd0);
        check({tag, "_sign"}, 64'(div_sign), 64'd0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] b,
                              input int max_gap);
        logic [71:0] fr;
        fr = {cmd, a, b};
        for (int i = 0; i < 9; i++) begin
            send_byte(fr[71:64]);
            fr = fr << 8;
            if (i != 8) repeat ($urandom_range(0, max_gap)) @(negedge clk);
        end
    endtask

    // Collect 8 response bytes; optionally stall 10 cycles on byte stall_idx
    task automatic recv_frame(input string tag, input int stall_idx, output logic [63:0] got,
                              output int send_cycles);
        int   n = 0;
        int   t = 0;
        int   stall = stall_idx;
        logic [7:0] held;
        bit   stable = 1'b1;
        got = 64'd0;
        send_cycles = 0;
        tx_ready = 1'b1;
        while (!tx_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_tx_start"}, 64'(tx_valid), 64'd1);
        while (n < 8 && t < 400) begin
            if (n == stall) begin
                tx_ready = 1'b0;
                held = tx_data;
                repeat (10) begin
                    @(negedge clk);
                    if (tx_valid !== 1'b1 || tx_data !== held) stable = 1'b0;
                end
                check({tag, "_bp_stable"}, 64'(stable), 64'd1);
                tx_ready = 1'b1;
                stall = -1;
            end
            if (tx_valid) begin
                got = {got[55:0], tx_data};
                n++;
            end
            @(negedge clk);
            t++;
            send_cycles++;
        end
        check({tag, "_end"}, 64'({tx_valid, busy}), 64'd0);
    endtask

    task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [31:0] a,
                             input logic [31:0] b, input logic [63:0] exp, input int stall_idx,
                             input int max_gap);
        logic [63:0] got;
        int sc;
        send_frame(cmd, a, b, max_gap);
        check({tag, "_rx_drop_last"}, 64'(rx_drop), 64'd0);
        check({tag, "_ops"}, {div_dividend, div_divider}, {a, b});
        check({tag, "_sign_busy"}, 64'({div_sign, busy}), 64'({cmd[0], 1'b1}));
        recv_frame(tag, stall_idx, got, sc);
        check({tag, "_data"}, got, exp);
        if (stall_idx < 0) check({tag, "_send_len"}, 64'(sc), 64'd8);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        int          t;
        logic [63:0] got;
        int          sc;

        rst      = 1'b1;
        rx_data  = 8'd0;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Test plan directed frames
        run_frame("u100_7", 8'hA0, 32'd100, 32'd7, 64'h0000000E_00000002, -1, 0);
        run_frame("s-100_7", 8'hA1, 32'hFFFF_FF9C, 32'd7, 64'hFFFFFFF2_FFFFFFFE, -1, 1);
        run_frame("u5_0", 8'hA0, 32'd5, 32'd0, 64'hFFFFFFFF_00000005, -1, 0);

        // Bad command byte: one frame_err pulse, no response, then a good frame
        send_byte(8'h55);
        check("bad_cmd_err", 64'({frame_err, busy}), 64'b10);
        @(negedge clk);
        check("bad_cmd_pulse", 64'(frame_err), 64'd0);
        repeat (5) @(negedge clk);
        check("bad_cmd_no_tx", 64'(tx_valid), 64'd0);
        run_frame("after_bad", 8'hA0, 32'd100, 32'd7, 64'h0000000E_00000002, -1, 0);

        // Backpressure on byte 3
        run_frame("bp", 8'hA0, 32'h1234_5678, 32'h0000_1234,
                  ref_div(32'h1234_5678, 32'h0000_1234, 1'b0), 3, 0);

        // Asynchronous reset in the middle of BUSY
        send_frame(8'hA0, 32'd77, 32'd3, 0);
        t = 0;
        while (!div_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("mid_busy_load_seen", 64'(div_ready), 64'd1);
        repeat (10) @(negedge clk);
        check("mid_busy_busy", 64'({busy, tx_valid}), 64'b10);
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        check("post_rst_idle", 64'({busy, tx_valid}), 64'd0);

        // Fresh 1000/10 frame with stray bytes in WAIT_LOAD and SEND
        send_frame(8'hA0, 32'd1000, 32'd10, 0);
        check("f1000_last_byte_kept", 64'(rx_drop), 64'd0);
        send_byte(8'h33);
        check("f1000_drop_wait", 64'(rx_drop), 64'd1);
        tx_ready = 1'b0;
        t = 0;
        while (!tx_valid && t < 200) begin
            @(negedge clk);
            t++;
        end
        check("f1000_tx_up", 64'(tx_valid), 64'd1);
        for (int k = 0; k < 2; k++) begin
            send_byte(8'($urandom));
            check("f1000_drop_send", 64'(rx_drop), 64'd1);
            @(negedge clk);
            check("f1000_drop_clear", 64'({rx_drop, tx_valid}), 64'b01);
        end
        recv_frame("f1000", -1, got, sc);
        check("f1000_data", got, 64'h00000064_00000000);
        check("f1000_send_len", 64'(sc), 64'd8);

        // Randomized frames against the arithmetic reference
        for (int i = 0; i < 10; i++) begin
            cmd = ($urandom_range(0, 1) == 0) ? 8'hA0 : 8'hA1;
            a   = $urandom;
            b   = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 300)) : 32'($urandom);
            if (cmd[0] && b == 32'hFFFF_FFFF) b = 32'd3;
            repeat ($urandom_range(0, 40)) @(negedge clk);
            run_frame($sformatf("rnd%0d", i), cmd, a, b, ref_div(a, b, cmd[0]),
                      ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1, 2);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
